neokeon_round_ctrl: RTL and testbench
=====================================

Name: neokeon_round_ctrl

Overview:
Round sequencer for the Neokeon-128 core. Steps the round datapath through 16 rounds plus the final output step, for both encryption and decryption. Generates the per-round constant pair in the same form that the round-constant function consumes (constant1/constant2). Provides a start/busy/done handshake to the top level and a hold input so the datapath can stall.

Parameters:
ROUNDS, 16, number of full rounds; fixed by the cipher, not to be overridden.
RC_ENC_INIT, 8'h80, first encryption round constant.
RC_DEC_INIT, 8'hD4, first decryption round constant.

Ports:
inClk  input  1  clock, rising edge.
inRst  input  1  asynchronous reset, active-high.
inStart  input  1  start request; sampled only in IDLE.
inDecrypt  input  1  mode select: 0 = encrypt, 1 = decrypt; latched with inStart.
inHold  input  1  datapath stall; freezes state, counter and constants while high.
outBusy  output  1  high in every state except IDLE.
outKeyPrep  output  1  decrypt only: apply Theta with the null vector to the working key this cycle.
outRoundEn  output  1  apply one round this cycle using outConst1/outConst2.
outFinal  output  1  apply the final step this cycle.
outDone  output  1  one-cycle pulse; the result is valid.
outRound  output  5  current round index, 0..16.
outConst1  output  8  constant1 for the round datapath.
outConst2  output  8  constant2 for the round datapath.

Behaviour:
- Reset (asynchronous): state IDLE, outRound=0, the constant register holds 8'h00, all outputs 0. Reset mid-operation aborts immediately; no outDone is produced.
- States: IDLE -> (KEYPREP if decrypt) -> ROUND -> FINAL -> DONE -> IDLE.
- IDLE: if inStart=1, latch inDecrypt and load the constant register (RC_ENC_INIT for encrypt, RC_DEC_INIT for decrypt). Next state is ROUND (encrypt) or KEYPREP (decrypt). inHold is ignored in IDLE.
- KEYPREP: outKeyPrep=1 for one cycle, then ROUND.
- ROUND: outRoundEn=1.
  - Encrypt: outConst1=reg, outConst2=0.
  - Decrypt: outConst1=0, outConst2=reg.
  - On each non-held cycle, outRound increments and the register advances:
    - encrypt step (xtime): rc = {rc[6:0],1'b0} ^ (rc[7] ? 8'h1B : 0);
    - decrypt step (inverse): rc = rc[0] ? ({1'b0,rc[7:1]} ^ 8'h8D) : {1'b0,rc[7:1]}. Example: 8'h1B -> 8'h80, 8'h36 -> 8'h1B.
  - After the round with outRound=15 completes: next state FINAL, outRound=16.
- FINAL: outFinal=1, outConst2=0.
  - Encrypt: outConst1=8'hD4 (the register value after 16 steps).
  - Decrypt: outConst1=8'h80 (the register value after 16 inverse steps).
  - Next state DONE.
- DONE: outDone=1 for exactly one cycle, outBusy=1. Next state IDLE with outRound=0.
- inHold=1 in KEYPREP/ROUND/FINAL: state, outRound and the constant register all hold. The enable outputs stay asserted, and the datapath must qualify them with its own hold.
- inHold in DONE is ignored; outDone is never stretched.
- inStart while busy is ignored; it is not queued.
- inStart asserted in the same cycle that DONE returns to IDLE is not sampled. It is sampled on the next IDLE cycle.
- inDecrypt changes while busy have no effect.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Latency with no hold: encrypt, start sampled at edge 0 -> ROUND cycles 1..16, FINAL 17, outDone 18; decrypt adds 1 cycle (outDone 19).

Optional Feature:
NEOKEON_ABORT_EN
- Defined: adds input inAbort (1 bit). When inAbort=1 in any busy state, the block returns to IDLE on the next edge, clears outRound and the constant register, and produces no outDone. inAbort has priority over inHold. inAbort in IDLE has no effect.
- Undefined: the port is absent; only inRst terminates an operation.

Test Plan:
- Encrypt, no hold: pulse inStart, inDecrypt=0 -> outConst1 sequence 80,1B,36,6C,D8,AB,4D,9A,2F,5E,BC,63,C6,97,35,6A with outConst2=0; FINAL outConst1=D4; outDone at cycle 18, exactly 1 cycle wide.
- Decrypt, no hold: inDecrypt=1 -> outKeyPrep at cycle 1; outConst2 sequence D4,6A,35,97,C6,63,BC,5E,2F,9A,4D,AB,D8,6C,36,1B with outConst1=0; FINAL outConst1=80; outDone at cycle 19.
- Hold: encrypt with inHold=1 for 3 cycles while outRound=5 -> outConst1 stays AB and outRound stays 5 for 4 cycles; outDone at cycle 21.
- Reset mid-run: assert inRst while outRound=7 -> all outputs 0 asynchronously; no outDone. A following inStart then runs a clean full sequence starting at 80.
- Ignored start: inStart held high throughout a run -> the second operation begins only in the first IDLE cycle after DONE; outBusy is low for exactly 1 cycle between runs.
- NEOKEON_ABORT_EN: inAbort=1 while outRound=10 -> IDLE next cycle, outBusy=0, outDone never asserted.

Source files
------------

// File: rtl/neokeon_round_ctrl.sv
// neokeon_round_ctrl
// Round sequencer for the Neokeon-128 core. Walks the round datapath through
// 16 rounds plus the final output step, for encryption or decryption, and
// produces the per-round constant pair (constant1/constant2) in the form the
// round-constant function consumes.
//
// Ports:
//   inClk       clock, rising edge
//   inRst       asynchronous reset, active-high
//   inStart     start request, sampled only in IDLE
//   inDecrypt   0 = encrypt, 1 = decrypt; latched together with inStart
//   inHold      datapath stall; freezes state, round counter and constant
//   inAbort     (only with NEOKEON_ABORT_EN) drop the operation, back to IDLE
//   outBusy     high in every state except IDLE
//   outKeyPrep  decrypt only: apply Theta with the null vector to the key
//   outRoundEn  apply one round using outConst1/outConst2
//   outFinal    apply the final step
//   outDone     one-cycle pulse, result valid
//   outRound    current round index 0..16
//   outConst1   constant1 for the round datapath
//   outConst2   constant2 for the round datapath
//
// Handshake: inStart is a request sampled only while outBusy is low; it is
// never queued. The enables are levels; while inHold is high they remain
// asserted and the datapath must qualify them with its own hold.
//
// Optional feature macro: NEOKEON_ABORT_EN (adds the inAbort port).
// All outputs are decoded from registered state only.

module neokeon_round_ctrl #(
  parameter logic [7:0] RC_ENC_INIT = 8'h80,
  parameter logic [7:0] RC_DEC_INIT = 8'hD4
) (
  input  logic       inClk,
  input  logic       inRst,
  input  logic       inStart,
  input  logic       inDecrypt,
  input  logic       inHold,
`ifdef NEOKEON_ABORT_EN
  input  logic       inAbort,
`endif
  output logic       outBusy,
  output logic       outKeyPrep,
  output logic       outRoundEn,
  output logic       outFinal,
  output logic       outDone,
  output logic [4:0] outRound,
  output logic [7:0] outConst1,
  output logic [7:0] outConst2
);

  // Fixed by the cipher; kept local so it cannot be overridden.
  localparam int ROUNDS = 16;
  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KEYPREP = 3'd1,
    S_ROUND   = 3'd2,
    S_FINAL   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t     state;
  logic [4:0] roundCnt;
  logic [7:0] rcReg;
  logic       decMode;
  logic       abortReq;

`ifdef NEOKEON_ABORT_EN
  assign abortReq = inAbort;
`else
  assign abortReq = 1'b0;
`endif

  // Forward constant step: multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] rcFwd(input logic [7:0] rc);
    return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
  endfunction

  // Inverse step: divide by x; 8'h8D is the reduction polynomial shifted right.
  function automatic logic [7:0] rcInv(input logic [7:0] rc);
    return rc[0] ? ({1'b0, rc[7:1]} ^ 8'h8D) : {1'b0, rc[7:1]};
  endfunction

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      state    <= S_IDLE;
      roundCnt <= 5'd0;
      rcReg    <= 8'h00;
      decMode  <= 1'b0;
    end else if (abortReq && (state != S_IDLE)) begin
      // Abort outranks hold and skips DONE, so no result pulse is produced.
      state    <= S_IDLE;
      roundCnt <= 5'd0;
      rcReg    <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (inStart) begin
            decMode  <= inDecrypt;
            rcReg    <= inDecrypt ? RC_DEC_INIT : RC_ENC_INIT;
            roundCnt <= 5'd0;
            state    <= inDecrypt ? S_KEYPREP : S_ROUND;
          end
        end
        S_KEYPREP: begin
          if (!inHold) state <= S_ROUND;
        end
        S_ROUND: begin
          if (!inHold) begin
            // The register also steps after the last round, so in FINAL it
            // already holds the output-step constant.
            rcReg    <= decMode ? rcInv(rcReg) : rcFwd(rcReg);
            roundCnt <= roundCnt + 5'd1;
            if (roundCnt == LAST_ROUND) state <= S_FINAL;
          end
        end
        S_FINAL: begin
          if (!inHold) state <= S_DONE;
        end
        S_DONE: begin
          // Hold is deliberately ignored here so the pulse is never stretched.
          state    <= S_IDLE;
          roundCnt <= 5'd0;
        end
        default: begin
          state    <= S_IDLE;
          roundCnt <= 5'd0;
        end
      endcase
    end
  end

  assign outBusy    = (state != S_IDLE);
  assign outKeyPrep = (state == S_KEYPREP);
  assign outRoundEn = (state == S_ROUND);
  assign outFinal   = (state == S_FINAL);
  assign outDone    = (state == S_DONE);
  assign outRound   = roundCnt;

  // Encrypt drives constant1, decrypt drives constant2; FINAL always uses
  // constant1 with constant2 zero.
  assign outConst1 = ((state == S_ROUND) && !decMode) ? rcReg :
                     (state == S_FINAL)               ? rcReg : 8'h00;
  assign outConst2 = ((state == S_ROUND) && decMode)  ? rcReg : 8'h00;

endmodule

// File: tb/tb_neokeon_round_ctrl.sv
// Self-checking bench for neokeon_round_ctrl.
module tb_neokeon_round_ctrl;

  // ---------------- clock / reset ----------------
  logic       inClk = 1'b0;
  logic       inRst = 1'b1;
  logic       inStart = 1'b0;
  logic       inDecrypt = 1'b0;
  logic       inHold = 1'b0;
  logic       inAbort = 1'b0;
  logic       outBusy, outKeyPrep, outRoundEn, outFinal, outDone;
  logic [4:0] outRound;
  logic [7:0] outConst1, outConst2;

  always #5 inClk = ~inClk;

  neokeon_round_ctrl dut (
    .inClk(inClk),
    .inRst(inRst),
    .inStart(inStart),
    .inDecrypt(inDecrypt),
    .inHold(inHold),
`ifdef NEOKEON_ABORT_EN
    .inAbort(inAbort),
`endif
    .outBusy(outBusy),
    .outKeyPrep(outKeyPrep),
    .outRoundEn(outRoundEn),
    .outFinal(outFinal),
    .outDone(outDone),
    .outRound(outRound),
    .outConst1(outConst1),
    .outConst2(outConst2)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each queue entry is one operation step: {keyPrep, roundEn, final, done,
  // round[4:0], const1[7:0], const2[7:0]}. A held step is simply not popped.
  localparam int W = 25;
  logic [W-1:0] exp_q[$];
  int encRc[0:16];

  function automatic logic [W-1:0] mk(input logic kp, input logic re, input logic fi,
                                      input logic dn, input int rnd, input int c1, input int c2);
    return {kp, re, fi, dn, 5'(rnd), 8'(c1), 8'(c2)};
  endfunction

  // GF(2^8) powers of x starting at 0x80: plain integer multiply-and-reduce.
  initial begin
    encRc[0] = 'h80;
    for (int i = 1; i <= 16; i++) begin
      encRc[i] = encRc[i-1] * 2;
      if (encRc[i] >= 256) encRc[i] = encRc[i] ^ 'h11B;
    end
  end

  // Decryption walks the encryption constants backwards.
  task automatic model_build(input logic dec);
    if (dec) begin
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 16; i++) exp_q.push_back(mk(0, 1, 0, 0, i, 0, encRc[16-i]));
      exp_q.push_back(mk(0, 0, 1, 0, 16, encRc[0], 0));
    end else begin
      for (int i = 0; i < 16; i++) exp_q.push_back(mk(0, 1, 0, 0, i, encRc[i], 0));
      exp_q.push_back(mk(0, 0, 1, 0, 16, encRc[16], 0));
    end
    exp_q.push_back(mk(0, 0, 0, 1, 16, 0, 0));
  endtask

  always @(posedge inClk or posedge inRst) begin
    if (inRst) exp_q.delete();
    else if (exp_q.size() == 0) begin
      if (inStart) model_build(inDecrypt);
    end
`ifdef NEOKEON_ABORT_EN
    else if (inAbort) exp_q.delete();
`endif
    else if (exp_q[0][W-4] || !inHold) void'(exp_q.pop_front());
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge inClk) begin
    logic [W:0] expV, actV;
    expV = (exp_q.size() != 0) ? {1'b1, exp_q[0]} : '0;
    actV = {outBusy, outKeyPrep, outRoundEn, outFinal, outDone, outRound, outConst1, outConst2};
    nChecks++;
    if (actV !== expV) begin
      nFails++;
      $display("FAIL cycle_outputs: got %h expected %h (busy,kp,re,fin,done,rnd,c1,c2) at %0t",
               actV, expV, $time);
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] seen[0:16];
  logic [7:0] encLit[0:16] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A, 8'h2F,
                               8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4};
  logic [7:0] decLit[0:16] = '{8'hD4, 8'h6A, 8'h35, 8'h97, 8'hC6, 8'h63, 8'hBC, 8'h5E, 8'h2F,
                               8'h9A, 8'h4D, 8'hAB, 8'hD8, 8'h6C, 8'h36, 8'h1B, 8'h80};

  // Leaves the bench at the negedge of cycle 1 (start sampled at edge 0).
  task automatic start_op(input logic dec);
    @(negedge inClk);
    inDecrypt = dec;
    inStart   = 1'b1;
    @(negedge inClk);
    inStart   = 1'b0;
  endtask

  // Follows a run from cycle 1 until outDone, recording the constants and
  // optionally stalling for holdLen cycles once outRound reaches holdRound.
  task automatic watch_run(input logic dec, input int holdRound, input int holdLen,
                           output int doneCyc, output int holdSeen);
    int cyc;
    int hc;
    cyc = 1; hc = 0; doneCyc = 0; holdSeen = 0;
    for (int i = 0; i < 17; i++) seen[i] = 8'h00;
    while (doneCyc == 0 && cyc < 60) begin
      if (outRoundEn) seen[outRound] = dec ? outConst2 : outConst1;
      if (outFinal) seen[16] = outConst1;
      if (outRoundEn && int'(outRound) == holdRound) holdSeen++;
      if (outDone) doneCyc = cyc;
      else begin
        if (outRoundEn && int'(outRound) == holdRound && hc < holdLen) begin
          inHold = 1'b1;
          hc++;
        end else inHold = 1'b0;
        @(negedge inClk);
        cyc++;
      end
    end
    inHold = 1'b0;
    if (doneCyc == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int doneCyc, holdSeen, n;

    repeat (2) @(negedge inClk);
    inRst = 1'b0;
    @(negedge inClk);
    check("reset_state", {outBusy, outKeyPrep, outRoundEn, outFinal, outDone, outRound,
                          outConst1, outConst2}, 32'd0);

    // Encrypt, no hold.
    start_op(1'b0);
    check("enc_first_const", outConst1, 32'h80);
    watch_run(1'b0, -1, 0, doneCyc, holdSeen);
    check("enc_done_cycle", doneCyc, 18);
    for (int i = 0; i < 17; i++) check($sformatf("enc_const_%0d", i), seen[i], encLit[i]);
    @(negedge inClk);
    check("enc_done_width", outDone, 0);

    // Decrypt, no hold.
    start_op(1'b1);
    check("dec_keyprep_cycle1", outKeyPrep, 1);
    watch_run(1'b1, -1, 0, doneCyc, holdSeen);
    check("dec_done_cycle", doneCyc, 19);
    for (int i = 0; i < 17; i++) check($sformatf("dec_const_%0d", i), seen[i], decLit[i]);
    @(negedge inClk);

    // Encrypt with a 3-cycle hold on round 5.
    start_op(1'b0);
    watch_run(1'b0, 5, 3, doneCyc, holdSeen);
    check("hold_round5_cycles", holdSeen, 4);
    check("hold_round5_const", seen[5], 32'hAB);
    check("hold_done_cycle", doneCyc, 21);
    @(negedge inClk);

    // Asynchronous reset mid-run at round 7.
    start_op(1'b0);
    n = 0;
    while (outRound != 5'd7 && n < 40) begin
      @(negedge inClk);
      n++;
    end
    check("reach_round7", outRound, 7);
    #3 inRst = 1'b1;
    #1 check("async_reset_outputs", {outBusy, outKeyPrep, outRoundEn, outFinal, outDone,
                                     outRound, outConst1, outConst2}, 32'd0);
    @(negedge inClk);
    inRst = 1'b0;
    @(negedge inClk);
    start_op(1'b0);
    watch_run(1'b0, -1, 0, doneCyc, holdSeen);
    check("post_reset_first_const", seen[0], 32'h80);
    check("post_reset_done_cycle", doneCyc, 18);
    @(negedge inClk);

    // inStart held high through a run; inDecrypt flipped while busy.
    @(negedge inClk);
    inDecrypt = 1'b0;
    inStart   = 1'b1;
    n = 0;
    while (!outDone && n < 60) begin
      @(negedge inClk);
      n++;
      if (n == 5) inDecrypt = 1'b1;
    end
    check("held_start_done_seen", outDone, 1);
    n = 0;
    @(negedge inClk);
    while (!outBusy && n < 10) begin
      @(negedge inClk);
      n++;
    end
    check("idle_gap_cycles", n, 1);
    inStart = 1'b0;
    check("second_run_is_decrypt", outKeyPrep, 1);
    watch_run(1'b1, -1, 0, doneCyc, holdSeen);
    check("second_run_done_cycle", doneCyc, 19);
    @(negedge inClk);

`ifdef NEOKEON_ABORT_EN
    // Abort at round 10 under a concurrent hold.
    start_op(1'b0);
    n = 0;
    while (outRound != 5'd10 && n < 40) begin
      @(negedge inClk);
      n++;
    end
    inAbort = 1'b1;
    inHold  = 1'b1;
    @(negedge inClk);
    inAbort = 1'b0;
    inHold  = 1'b0;
    check("abort_idle", {outBusy, outRound}, 32'd0);
    n = 0;
    repeat (5) begin
      @(negedge inClk);
      if (outDone) n++;
    end
    check("abort_no_done", n, 0);
`endif

    repeat (2) @(negedge inClk);
    check("model_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
